// File: rtl/cpu_types_pkg.sv
// Shared CPU memory-system types: RAM port status and arbiter grant states.
package cpu_types_pkg;

  typedef enum logic [1:0] {
    FREE   = 2'd0,
    BUSY   = 2'd1,
    ACCESS = 2'd2,
    ERROR  = 2'd3
  } ramstate_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    IGNT = 2'd1,
    DGNT = 2'd2
  } arb_state_t;

  localparam int WORD_W_DEF     = 32;
  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_arbiter_if.sv
// Cache-pair and RAM-port signal bundle around mem_arbiter.
// slave = arbiter view, master = caches + RAM model view.
interface mem_arbiter_if
  import cpu_types_pkg::*;
#(
  parameter int WORD_W = WORD_W_DEF
) ();

  logic              iREN;
  logic [WORD_W-1:0] iaddr;
  logic              dREN;
  logic              dWEN;
  logic [WORD_W-1:0] daddr;
  logic [WORD_W-1:0] dstore;
  logic              iwait;
  logic              dwait;
  logic [WORD_W-1:0] iload;
  logic [WORD_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [WORD_W-1:0] ramaddr;
  logic [WORD_W-1:0] ramstore;
  logic [WORD_W-1:0] ramload;
  ramstate_t         ramstate;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, dwait, iload, dload, ramREN, ramWEN, ramaddr, ramstore
  );

endinterface

// File: rtl/mem_arbiter.sv
// Shares the single RAM port between icache and dcache, dcache first.
// Define MEM_ARB_FAIR_EN to bound icache starvation to STARVE_MAX dcache grants.
//
// state | meaning
// IDLE  | no grant, RAM port quiet
// IGNT  | icache owns the RAM port
// DGNT  | dcache owns the RAM port
module mem_arbiter
  import cpu_types_pkg::*;
#(
  parameter int WORD_W     = WORD_W_DEF,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic          CLK,
  input  logic          nRST,
  mem_arbiter_if.slave  bus
);

  if (STARVE_MAX < 1 || STARVE_MAX > 15) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be 1..15");
  end

  arb_state_t state_q, state_d, arb_pick;
  logic       dreq, acc, icomp, dcomp, force_i;

  assign dreq  = bus.dREN | bus.dWEN;
  assign acc   = (bus.ramstate == ACCESS);
  assign icomp = (state_q == IGNT) && bus.iREN && acc;
  assign dcomp = (state_q == DGNT) && dreq && acc;

`ifdef MEM_ARB_FAIR_EN
  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  logic [3:0] starve_q, starve_d;

  // Counter is zero while icache owns the port; it can only grow in DGNT.
  always_comb begin
    starve_d = starve_q;
    if (state_q == IGNT)
      starve_d = 4'd0;
    else if (dcomp && bus.iREN && (starve_q != 4'hF))
      starve_d = starve_q + 4'd1;
  end

  assign force_i = bus.iREN && (starve_d == STARVE_LIM);

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) starve_q <= 4'd0;
    else       starve_q <= starve_d;
  end
`else
  assign force_i = 1'b0;
`endif

  always_comb begin
    arb_pick = IDLE;
    if (force_i)       arb_pick = IGNT;
    else if (dreq)     arb_pick = DGNT;
    else if (bus.iREN) arb_pick = IGNT;
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Re-arbitrate on completion or when the owner withdraws; no IDLE bubble.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = arb_pick;
      IGNT:    if (!bus.iREN || icomp) state_d = arb_pick;
      DGNT:    if (!dreq || dcomp)     state_d = arb_pick;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.ramREN   = 1'b0;
    bus.ramWEN   = 1'b0;
    bus.ramaddr  = '0;
    bus.ramstore = '0;
    bus.iload    = '0;
    bus.dload    = '0;
    bus.iwait    = ~icomp;
    bus.dwait    = ~dcomp;
    case (state_q)
      IGNT: begin
        bus.ramREN  = bus.iREN;
        bus.ramaddr = bus.iaddr;
        bus.iload   = bus.ramload;
      end
      DGNT: begin
        bus.ramWEN   = bus.dWEN;
        bus.ramREN   = bus.dREN & ~bus.dWEN;
        bus.ramaddr  = bus.daddr;
        bus.ramstore = bus.dstore;
        bus.dload    = bus.ramload;
      end
      default: ;
    endcase
  end

endmodule
